// File: rtl/pkt_header_extract.sv
// Reads a packet header byte-by-byte from packet memory and presents four 16-bit fields with a done strobe.
// Optional macro HDR_CHECK_EN: also reads one XOR checksum byte after the header and flags a mismatch on hdr_error.
module pkt_header_extract #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned MEM_WIDTH  = 8,
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned HDR_BYTES  = 8
) (
    input  logic                  clock,
    input  logic                  nrst,
    input  logic                  en,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [MEM_WIDTH-1:0]  data_in,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  mem_rd,
    output logic [WORD_WIDTH-1:0] sourceID,
    output logic [WORD_WIDTH-1:0] destinationID,
    output logic [WORD_WIDTH-1:0] pktType,
    output logic [WORD_WIDTH-1:0] hopCount,
    output logic                  hdr_error,
    output logic                  done
);

`ifdef HDR_CHECK_EN
    localparam int unsigned NUM_RD = HDR_BYTES + 1;
`else
    localparam int unsigned NUM_RD = HDR_BYTES;
`endif
    localparam int unsigned IDX_W  = $clog2(NUM_RD + 1);
    localparam int unsigned SHD_W  = HDR_BYTES * MEM_WIDTH;
    localparam int unsigned F0_TOP = SHD_W - 1;
    localparam int unsigned F1_TOP = SHD_W - 1 - WORD_WIDTH;
    localparam int unsigned F2_TOP = SHD_W - 1 - 2 * WORD_WIDTH;
    localparam int unsigned F3_TOP = SHD_W - 1 - 3 * WORD_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_READ,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_clear;
    logic                    w_load;
    logic                    w_issue;
    logic                    w_copy;

    logic [ADDR_WIDTH-1:0]   r_base;
    logic [IDX_W-1:0]        r_idx;
    logic [IDX_W-1:0]        r_cap_idx;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_mem_rd;
    logic [SHD_W-1:0]        r_shadow;
    logic [WORD_WIDTH-1:0]   r_src;
    logic [WORD_WIDTH-1:0]   r_dst;
    logic [WORD_WIDTH-1:0]   r_type;
    logic [WORD_WIDTH-1:0]   r_hop;
    logic                    r_done;

    // State register
    always_ff @(posedge clock) begin
        if (!nrst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_load      = 1'b0;
        w_issue     = 1'b0;
        w_copy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_clear     = 1'b1;
                    w_state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                w_issue = 1'b1;
                if (r_idx == IDX_W'(NUM_RD - 1)) w_state_nxt = S_FLUSH;
            end
            S_FLUSH: w_state_nxt = S_DONE;
            S_DONE: begin
                w_copy      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef HDR_CHECK_EN
    logic [MEM_WIDTH-1:0] r_chk;
    logic [MEM_WIDTH-1:0] w_xor;
    logic                 r_hdr_err;

    always_comb begin
        w_xor = '0;
        for (int i = 0; i < HDR_BYTES; i++) begin
            w_xor = w_xor ^ r_shadow[i*MEM_WIDTH +: MEM_WIDTH];
        end
    end

    always_ff @(posedge clock) begin
        if (!nrst) begin
            r_chk     <= '0;
            r_hdr_err <= 1'b0;
        end else begin
            if (r_mem_rd && (r_cap_idx == IDX_W'(HDR_BYTES))) r_chk <= data_in;
            if (w_clear)     r_hdr_err <= 1'b0;
            else if (w_copy) r_hdr_err <= (w_xor != r_chk);
        end
    end

    assign hdr_error = r_hdr_err;
`else
    assign hdr_error = 1'b0;
`endif

    // Address issue, byte capture into big-endian shadow slots, output update
    always_ff @(posedge clock) begin
        if (!nrst) begin
            r_base    <= '0;
            r_idx     <= '0;
            r_cap_idx <= '0;
            r_addr    <= '0;
            r_mem_rd  <= 1'b0;
            r_shadow  <= '0;
            r_src     <= '0;
            r_dst     <= '0;
            r_type    <= '0;
            r_hop     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_mem_rd <= w_issue;
            if (w_load) begin
                r_base    <= base_addr;
                r_idx     <= '0;
                r_cap_idx <= '0;
            end
            if (w_issue) begin
                r_addr <= r_base + ADDR_WIDTH'(r_idx);
                r_idx  <= r_idx + IDX_W'(1);
            end
            // Data for the address issued last cycle arrives now
            if (r_mem_rd) begin
                for (int i = 0; i < HDR_BYTES; i++) begin
                    if (r_cap_idx == IDX_W'(i)) begin
                        r_shadow[(HDR_BYTES-1-i)*MEM_WIDTH +: MEM_WIDTH] <= data_in;
                    end
                end
                r_cap_idx <= r_cap_idx + IDX_W'(1);
            end
            if (w_clear) begin
                r_src  <= '0;
                r_dst  <= '0;
                r_type <= '0;
                r_hop  <= '0;
                r_done <= 1'b0;
            end else if (w_copy) begin
                r_src  <= r_shadow[F0_TOP -: WORD_WIDTH];
                r_dst  <= r_shadow[F1_TOP -: WORD_WIDTH];
                r_type <= r_shadow[F2_TOP -: WORD_WIDTH];
                r_hop  <= r_shadow[F3_TOP -: WORD_WIDTH];
                r_done <= 1'b1;
            end
        end
    end

    assign address       = r_addr;
    assign mem_rd        = r_mem_rd;
    assign sourceID      = r_src;
    assign destinationID = r_dst;
    assign pktType       = r_type;
    assign hopCount      = r_hop;
    assign done          = r_done;

endmodule
